// File: rtl/div_pkg.sv
// Shared state encoding and handshake constants for the multi-cycle divider.
package div_pkg;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_t;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/div.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle,
// result {remainder, quotient} held until EX drops start_i.
module div
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  div_state_t         state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [2*WIDTH:0]   work, work_n;
  logic [WIDTH-1:0]   dvsr, dvsr_n;
  logic               sgn, sgn_n;
  logic               neg_a, neg_a_n;
  logic               neg_b, neg_b_n;
  logic [2*WIDTH-1:0] result_n;
  logic               ready_n;

  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   quo, rem;
  logic [WIDTH-1:0]   mag_a, mag_b;

  always_comb begin
    mag_a = (signed_div_i && opdata1_i[WIDTH-1]) ? ('0 - opdata1_i) : opdata1_i;
    mag_b = (signed_div_i && opdata2_i[WIDTH-1]) ? ('0 - opdata2_i) : opdata2_i;
    // work[2W:W] is the partial remainder with the next dividend bit appended
    diff  = work[2*WIDTH:WIDTH] - {1'b0, dvsr};
    quo   = (sgn && (neg_a ^ neg_b)) ? ('0 - work[WIDTH-1:0]) : work[WIDTH-1:0];
    rem   = (sgn && neg_a) ? ('0 - work[2*WIDTH:WIDTH+1]) : work[2*WIDTH:WIDTH+1];
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    work_n   = work;
    dvsr_n   = dvsr;
    sgn_n    = sgn;
    neg_a_n  = neg_a;
    neg_b_n  = neg_b;
    result_n = result_o;
    ready_n  = ready_o;
    unique case (state)
      DIV_FREE: begin
        result_n = '0;
        ready_n  = DIV_RESULT_NOT_READY;
        if (start_i == DIV_START && !annul_i) begin
          if (opdata2_i == '0) begin
            state_n = DIV_BYZERO;
          end else begin
            state_n = DIV_ON;
            cnt_n   = '0;
            sgn_n   = signed_div_i;
            neg_a_n = signed_div_i & opdata1_i[WIDTH-1];
            neg_b_n = signed_div_i & opdata2_i[WIDTH-1];
            work_n  = {{WIDTH{1'b0}}, mag_a, 1'b0};
            dvsr_n  = mag_b;
          end
        end
      end
      DIV_BYZERO: begin
        state_n  = DIV_END;
        result_n = '0;
        ready_n  = DIV_RESULT_READY;
      end
      DIV_ON: begin
        if (annul_i) begin
          state_n  = DIV_FREE;
          result_n = '0;
          ready_n  = DIV_RESULT_NOT_READY;
        end else if (cnt != CNT_W'(WIDTH)) begin
          if (diff[WIDTH])
            work_n = {work[2*WIDTH-1:0], 1'b0};
          else
            work_n = {diff[WIDTH-1:0], work[WIDTH-1:0], 1'b1};
          cnt_n = cnt + 1'b1;
        end else begin
          state_n  = DIV_END;
          result_n = {rem, quo};
          ready_n  = DIV_RESULT_READY;
          cnt_n    = '0;
        end
      end
      DIV_END: begin
        if (start_i == DIV_STOP) begin
          state_n  = DIV_FREE;
          result_n = '0;
          ready_n  = DIV_RESULT_NOT_READY;
        end
      end
      default: state_n = DIV_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= DIV_FREE;
      cnt      <= '0;
      work     <= '0;
      dvsr     <= '0;
      sgn      <= 1'b0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      result_o <= '0;
      ready_o  <= DIV_RESULT_NOT_READY;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      work     <= work_n;
      dvsr     <= dvsr_n;
      sgn      <= sgn_n;
      neg_a    <= neg_a_n;
      neg_b    <= neg_b_n;
      result_o <= result_n;
      ready_o  <= ready_n;
    end
  end

endmodule

// File: tb/tb_div.sv
// Directed bench for the divider: hand-computed quotient/remainder pairs,
// latency, annul, reset and END-hold behaviour.
module tb_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1, op2;
  logic        start, annul;
  logic [63:0] result;
  logic        ready;

  int total = 0;
  int bad   = 0;

  div #(.WIDTH(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Accept one request, count edges to ready, check result, hold in END, release.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp,
                         input int exp_lat, input int hold);
    int n;
    signed_div = sgn;
    op1 = a;
    op2 = b;
    start = 1'b1;
    step();
    op1 = $urandom;
    op2 = $urandom;
    signed_div = ~sgn;
    n = 0;
    do begin
      step();
      n++;
    end while (!ready && n < 40);
    check({tag, "_lat"}, 64'(n), 64'(exp_lat));
    check({tag, "_res"}, result, exp);
    for (int i = 0; i < hold; i++) begin
      step();
      check({tag, "_hold_rdy"}, 64'(ready), 64'd1);
      check({tag, "_hold_res"}, result, exp);
    end
    start = 1'b0;
    step();
    check({tag, "_rel_rdy"}, 64'(ready), 64'd0);
    check({tag, "_rel_res"}, result, 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    annul = 1'b0;
    signed_div = 1'b0;
    op1 = '0;
    op2 = '0;
    step();
    step();
    rst = 1'b0;
    check("reset_rdy", 64'(ready), 64'd0);
    check("reset_res", result, 64'd0);
    step();

    run_div("u100_7",  1'b0, 32'd100,       32'd7,          64'h00000002_0000000E, 33, 0);
    run_div("s_m7_2",  1'b1, 32'hFFFFFFF9,  32'h00000002,   64'hFFFFFFFF_FFFFFFFD, 33, 0);
    run_div("s_7_m2",  1'b1, 32'h00000007,  32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 33, 0);
    run_div("byzero",  1'b0, 32'd5,         32'd0,          64'h0,                  1, 0);
    run_div("s_ovf",   1'b1, 32'h80000000,  32'hFFFFFFFF,   64'h00000000_80000000, 33, 0);
    run_div("u_max_1", 1'b0, 32'hFFFFFFFF,  32'h00000001,   64'h00000000_FFFFFFFF, 33, 0);
    run_div("u_big",   1'b0, 32'h80000000,  32'hFFFFFFFF,   64'h80000000_00000000, 33, 0);

    // Annul mid-division: ready must never rise.
    signed_div = 1'b0;
    op1 = 32'd100;
    op2 = 32'd7;
    start = 1'b1;
    step();
    for (int i = 0; i < 10; i++) step();
    annul = 1'b1;
    start = 1'b0;
    step();
    annul = 1'b0;
    check("annul_rdy", 64'(ready), 64'd0);
    check("annul_res", result, 64'd0);
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
        step();
        if (ready) seen = 1'b1;
      end
      check("annul_never_rdy", 64'(seen), 64'd0);
    end
    run_div("u9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33, 0);

    // Reset mid-division.
    op1 = 32'd1000;
    op2 = 32'd3;
    start = 1'b1;
    step();
    for (int i = 0; i < 20; i++) step();
    rst = 1'b1;
    start = 1'b0;
    step();
    rst = 1'b0;
    check("midrst_rdy", 64'(ready), 64'd0);
    check("midrst_res", result, 64'd0);
    step();
    check("midrst_idle_rdy", 64'(ready), 64'd0);

    // Long END hold.
    run_div("hold5", 1'b0, 32'd1000, 32'd3, 64'h00000001_0000014D, 33, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
